// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral with a parametrised register bank.
// Frames are MSB first: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// Writes commit only for exact-length frames to an implemented address; reads
// return register contents on CIPO. Rejected frames pulse frame_err and bump a
// saturating error counter.
module spi_regbank #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5,
  parameter int ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err,
  output logic [ERR_W-1:0]           err_count
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  // Counter must reach FRAME_W+1 so an over-length frame is distinguishable.
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  // Receive register only keeps what is ever inspected: the command byte at the
  // end of the address phase, and the data field at the end of the frame.
  localparam int RX_W    = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Synchroniser chains; index 1 is the synchronised value, index 2 the previous one.
  logic [2:0] sclk_q;
  logic [2:0] ncs_q;
  logic [1:0] copi_q;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, copi_sync, ncs_sync;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RX_W-1:0]   rx_q, rx_d, rx_shifted;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              cipo_q, cipo_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic              frame_err_q, frame_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              addr_ok;

  // Bring the asynchronous SPI pins into the clk domain, idling SCLK low and nCS high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      ncs_q  <= 3'b111;
      copi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      ncs_q  <= {ncs_q[1:0], nCS};
      copi_q <= {copi_q[0], COPI};
    end
  end

  assign sclk_rise  =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] &  sclk_q[2];
  assign cs_fall    = ~ncs_q[1]  &  ncs_q[2];
  assign cs_rise    =  ncs_q[1]  & ~ncs_q[2];
  assign copi_sync  =  copi_q[1];
  assign ncs_sync   =  ncs_q[1];
  assign rx_shifted = {rx_q[RX_W-2:0], copi_sync};
  assign addr_ok    = {1'b0, addr_q} < (ADDR_W + 1)'(NUM_REGS);

  // Frame FSM: shift in bits, preload read data, and validate/commit in DONE.
  // NOTE: every signal gets a default at the top so no path leaves a value
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    cipo_d      = 1'b0;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          rx_d    = '0;
        end
      end

      ST_CMD: begin
        if (cs_rise) begin
          state_d = ST_DONE;
        end else if (sclk_rise && !ncs_sync) begin
          rx_d  = rx_shifted;
          cnt_d = cnt_q + CNT_W'(1);
          // Last address bit: latch the command and preload read data so the
          // MSB can be driven on the very next SCLK fall.
          if (cnt_q == CNT_W'(ADDR_W)) begin
            state_d = ST_DATA;
            rw_d    = rx_shifted[ADDR_W];
            addr_d  = rx_shifted[ADDR_W-1:0];
            tx_d    = '0;
            if (!rx_shifted[ADDR_W]) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (rx_shifted[ADDR_W-1:0] == ADDR_W'(k)) tx_d = regs_q[k];
              end
            end
          end
        end
      end

      ST_DATA: begin
        cipo_d = cipo_q;
        if (cs_rise) begin
          state_d = ST_DONE;
        end else begin
          if (sclk_rise && !ncs_sync) begin
            rx_d = rx_shifted;
            if (cnt_q != CNT_W'(FRAME_W + 1)) cnt_d = cnt_q + CNT_W'(1);
          end
          if (sclk_fall) begin
            cipo_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
        end
      end

      default: begin  // ST_DONE
        state_d = ST_IDLE;
        if (cnt_q == CNT_W'(FRAME_W) && addr_ok) begin
          if (rw_q) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_q == ADDR_W'(k)) begin
                regs_d[k]      = rx_q[DATA_W-1:0];
                wr_strobe_d[k] = 1'b1;
              end
            end
          end
        end else begin
          frame_err_d = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
        end
      end
    endcase
  end

  // State and register-bank update; the bank resets because regs_out must read 0.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      tx_q        <= '0;
      cipo_q      <= 1'b0;
      regs_q      <= '{default: '0};
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      cipo_q      <= cipo_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign CIPO      = cipo_q;
  assign CIPO_oe   = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Bench for spi_regbank: a default instance (5 x 8-bit) and an overridden
// instance (8 x 16-bit, 2-bit error counter) share SCLK/COPI with separate nCS.
// A register/error-count model predicts each frame's outcome from the frame
// rules; one compare process checks outputs every clk against it.
module tb_spi_regbank;

  logic clk = 1'b0;
  logic rst_n, SCLK, COPI, ncs_a, ncs_b;

  logic         cipo_a, oe_a, ferr_a;
  logic [39:0]  regs_a;
  logic [4:0]   strb_a;
  logic [7:0]   errc_a;

  logic         cipo_b, oe_b, ferr_b;
  logic [127:0] regs_b;
  logic [7:0]   strb_b;
  logic [1:0]   errc_b;

  always #5 clk = ~clk;

  spi_regbank dut_a (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(ncs_a),
    .CIPO(cipo_a), .CIPO_oe(oe_a), .regs_out(regs_a), .wr_strobe(strb_a),
    .frame_err(ferr_a), .err_count(errc_a)
  );

  spi_regbank #(.DATA_W(16), .ADDR_W(7), .NUM_REGS(8), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(ncs_b),
    .CIPO(cipo_b), .CIPO_oe(oe_b), .regs_out(regs_b), .wr_strobe(strb_b),
    .frame_err(ferr_b), .err_count(errc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: committed expectation, pending outcome of the frame in flight.
  logic [39:0]  exp_regs_a = '0, pend_regs_a = '0;
  logic [4:0]   pend_strb_a = '0, last_strb_a = '0;
  logic [7:0]   exp_err_a = '0, pend_err_a = '0;
  bit           settle_a = 1'b1;
  int           strb_seen_a = 0, err_seen_a = 0;

  logic [127:0] exp_regs_b = '0, pend_regs_b = '0;
  logic [7:0]   pend_strb_b = '0, last_strb_b = '0;
  logic [1:0]   exp_err_b = '0, pend_err_b = '0;
  bit           settle_b = 1'b1;
  int           strb_seen_b = 0, err_seen_b = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model. Outside a settle window nothing may
  // move; inside it, any strobe/error pulse must match the predicted outcome.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!settle_a) begin
        check("a_regs", regs_a, exp_regs_a);
        check("a_errcnt", errc_a, exp_err_a);
        check("a_strobe_idle", strb_a, 0);
        check("a_ferr_idle", ferr_a, 0);
        if (ncs_a) begin
          check("a_oe_idle", oe_a, 0);
          check("a_cipo_idle", cipo_a, 0);
        end
      end else begin
        if (strb_a != 0) begin
          strb_seen_a++;
          last_strb_a = strb_a;
          check("a_strobe", strb_a, pend_strb_a);
          check("a_regs_with_strobe", regs_a, pend_regs_a);
        end
        if (ferr_a) begin
          err_seen_a++;
          check("a_errcnt_with_pulse", errc_a, pend_err_a);
        end
      end
      if (!settle_b) begin
        check("b_regs", regs_b, exp_regs_b);
        check("b_errcnt", errc_b, exp_err_b);
        check("b_strobe_idle", strb_b, 0);
        check("b_ferr_idle", ferr_b, 0);
        if (ncs_b) begin
          check("b_oe_idle", oe_b, 0);
          check("b_cipo_idle", cipo_b, 0);
        end
      end else begin
        if (strb_b != 0) begin
          strb_seen_b++;
          last_strb_b = strb_b;
          check("b_strobe", strb_b, pend_strb_b);
          check("b_regs_with_strobe", regs_b, pend_regs_b);
        end
        if (ferr_b) begin
          err_seen_b++;
          check("b_errcnt_with_pulse", errc_b, pend_err_b);
        end
      end
    end
  end

  // Reset both instances with nCS released; the model returns to all zeros.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    settle_a = 1'b1; settle_b = 1'b1;
    strb_seen_a = 0; err_seen_a = 0; strb_seen_b = 0; err_seen_b = 0;
    rst_n = 1'b0; ncs_a = 1'b1; ncs_b = 1'b1; SCLK = 1'b0; COPI = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    exp_regs_a = '0; exp_err_a = '0; exp_regs_b = '0; exp_err_b = '0;
    repeat (12) @(negedge clk);
    check("a_pulses_after_reset", strb_seen_a + err_seen_a, 0);
    check("b_pulses_after_reset", strb_seen_b + err_seen_b, 0);
    settle_a = 1'b0; settle_b = 1'b0;
  endtask

  // Send one frame of nbits (MSB first) to instance d, collect CIPO on each SCLK
  // rise during the data phase, and predict/verify the outcome. With keep_cs the
  // frame is left open (no prediction) so the caller can abort it.
  task automatic run_frame(input int d, input logic [31:0] bits, input int nbits,
                           input bit chk_lit, input logic [15:0] lit_rd,
                           input bit keep_cs);
    int fw, dw, nregs, addr;
    logic rw;
    logic [15:0] data, rd, mrd;
    bit ok;
    fw    = (d == 0) ? 16 : 24;
    dw    = (d == 0) ? 8 : 16;
    nregs = (d == 0) ? 5 : 8;
    rw    = bits[nbits-1];
    addr  = int'((bits >> (nbits - 8)) & 32'h7F);
    data  = 16'(bits & ((32'h1 << dw) - 1));
    ok    = (nbits == fw) && (addr < nregs);
    mrd   = '0;
    if (ok && !rw) mrd = (d == 0) ? 16'(exp_regs_a[addr*8 +: 8]) : exp_regs_b[addr*16 +: 16];
    rd = '0;

    @(negedge clk);
    if (d == 0) ncs_a = 1'b0; else ncs_b = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      COPI = bits[nbits-1-i];
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      check("oe_in_frame", (d == 0) ? oe_a : oe_b, 1);
      if (i >= 8) rd = {rd[14:0], (d == 0) ? cipo_a : cipo_b};
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (keep_cs) return;
    repeat (4) @(negedge clk);
    if (nbits == fw) check("read_data_model", rd, mrd);
    if (chk_lit) check("read_data_literal", rd, lit_rd);

    if (d == 0) begin
      pend_regs_a = exp_regs_a; pend_strb_a = '0; pend_err_a = exp_err_a;
      if (ok && rw) begin
        pend_regs_a[addr*8 +: 8] = data[7:0];
        pend_strb_a = 5'(1 << addr);
      end else if (!ok) begin
        pend_err_a = (exp_err_a == 8'hFF) ? 8'hFF : exp_err_a + 8'd1;
      end
      strb_seen_a = 0; err_seen_a = 0; settle_a = 1'b1;
      ncs_a = 1'b1;
    end else begin
      pend_regs_b = exp_regs_b; pend_strb_b = '0; pend_err_b = exp_err_b;
      if (ok && rw) begin
        pend_regs_b[addr*16 +: 16] = data;
        pend_strb_b = 8'(1 << addr);
      end else if (!ok) begin
        pend_err_b = (exp_err_b == 2'd3) ? 2'd3 : exp_err_b + 2'd1;
      end
      strb_seen_b = 0; err_seen_b = 0; settle_b = 1'b1;
      ncs_b = 1'b1;
    end
    repeat (12) @(negedge clk);
    if (d == 0) begin
      check("a_strobe_pulses", strb_seen_a, (ok && rw) ? 1 : 0);
      check("a_err_pulses", err_seen_a, ok ? 0 : 1);
      exp_regs_a = pend_regs_a; exp_err_a = pend_err_a;
      settle_a = 1'b0;
    end else begin
      check("b_strobe_pulses", strb_seen_b, (ok && rw) ? 1 : 0);
      check("b_err_pulses", err_seen_b, ok ? 0 : 1);
      exp_regs_b = pend_regs_b; exp_err_b = pend_err_b;
      settle_b = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; SCLK = 1'b0; COPI = 1'b0; ncs_a = 1'b1; ncs_b = 1'b1;
    do_reset(4);
    check("reset_regs_a", regs_a, 0);
    check("reset_errc_a", errc_a, 0);
    check("reset_oe_a", oe_a, 0);
    check("reset_cipo_a", cipo_a, 0);
    check("reset_strobe_a", strb_a, 0);
    check("reset_ferr_a", ferr_a, 0);
    check("reset_regs_b", regs_b, 0);

    // Write 0x55 to register 2.
    run_frame(0, 32'h8255, 16, 1'b0, 16'h0, 1'b0);
    check("lit_write_reg2", regs_a, 40'h00_00_55_00_00);
    check("lit_write_strobe", last_strb_a, 5'b00100);
    check("lit_write_errc", errc_a, 0);

    // Read register 2 back: 0x55 = 0,1,0,1,0,1,0,1 on CIPO.
    run_frame(0, 32'h0200, 16, 1'b1, 16'h0055, 1'b0);

    // Write to address 5, beyond the last register, must be rejected.
    run_frame(0, 32'h85AA, 16, 1'b0, 16'h0, 1'b0);
    check("lit_bad_addr_regs", regs_a, 40'h00_00_55_00_00);
    check("lit_bad_addr_errc", errc_a, 1);

    // Under-length and over-length frames.
    run_frame(0, 32'h412A, 15, 1'b0, 16'h0, 1'b0);
    run_frame(0, 32'h104AA, 17, 1'b0, 16'h0, 1'b0);
    check("lit_len_errc", errc_a, 3);

    // Reset after 10 bits of 0x80FF: frame discarded, everything cleared.
    run_frame(0, 32'h203, 10, 1'b0, 16'h0, 1'b1);
    do_reset(1);
    check("lit_midreset_regs", regs_a, 0);
    check("lit_midreset_errc", errc_a, 0);
    run_frame(0, 32'h80FF, 16, 1'b0, 16'h0, 1'b0);
    check("lit_reg0_ff", regs_a, 40'h00_00_00_00_FF);

    // Wide instance: write/read register 7, then five rejected frames.
    run_frame(1, 32'h87BEEF, 24, 1'b0, 16'h0, 1'b0);
    check("lit_b_reg7", regs_b[127:112], 16'hBEEF);
    check("lit_b_strobe", last_strb_b, 8'h80);
    run_frame(1, 32'h070000, 24, 1'b1, 16'hBEEF, 1'b0);
    run_frame(1, 32'h881234, 24, 1'b0, 16'h0, 1'b0);
    run_frame(1, 32'h43DF77, 23, 1'b0, 16'h0, 1'b0);
    run_frame(1, 32'h10F7DDE, 25, 1'b0, 16'h0, 1'b0);
    run_frame(1, 32'h090000, 24, 1'b0, 16'h0, 1'b0);
    run_frame(1, 32'h7F0000, 24, 1'b0, 16'h0, 1'b0);
    check("lit_b_errc_sat", errc_b, 2'd3);
    check("lit_b_regs_kept", regs_b, {16'hBEEF, 112'h0});
    check("lit_a_untouched", regs_a, 40'h00_00_00_00_FF);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
